uart_frame_parser: RTL and testbench

Byte-stream deframer directly downstream of the UART receiver: consumes the one-cycle byte-valid strobe and byte, recognises a fixed command frame, and assembles its payload into an N-bit Hopfield pattern word. A validated frame is presented to the network controller as a command code plus pattern, with a single-cycle valid strobe. Malformed, corrupted or stalled frames are dropped and flagged.

---
 rtl/uart_frame_parser_if.sv | 23 ++
 rtl/uart_frame_parser.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream side and frame-result side of the UART frame parser.
// slave = parser, master = whoever feeds bytes and consumes frames.
interface uart_frame_parser_if #(
  parameter int N_NEURONS = 64
);
  logic                 i_Rx_DV;
  logic [7:0]           i_Rx_Byte;
  logic [7:0]           o_Cmd;
  logic [N_NEURONS-1:0] o_Pattern;
  logic                 o_Frame_Valid;
  logic                 o_Frame_Error;
  logic                 o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Cmd, o_Pattern, o_Frame_Valid, o_Frame_Error, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Cmd, o_Pattern, o_Frame_Valid, o_Frame_Error, o_Busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Deframes SYNC/CMD/LEN/payload[/CHK] into a command + N-bit pattern.
// Define UART_FRAME_CHECKSUM_EN to require and verify the XOR CHK byte.
module uart_frame_parser #(
  parameter int         N_NEURONS    = 64,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input logic                i_Clock,
  input logic                i_Reset,
  uart_frame_parser_if.slave bus
);
  localparam int PL = (N_NEURONS + 7) / 8;
  localparam int SW = PL * 8;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0]    PL_B   = 8'(PL);
  localparam logic [7:0]    PL_LST = 8'(PL - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           scmd_q, scmd_d;
  logic [SW-1:0]        shadow_q, shadow_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [N_NEURONS-1:0] pat_q, pat_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif

  // Next-state, byte assembly, timeout and commit decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    scmd_d   = scmd_q;
    shadow_d = shadow_q;
    cmd_d    = cmd_q;
    pat_d    = pat_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    // A byte on the expiry cycle takes priority over the timeout.
    if (state_q != S_IDLE && !bus.i_Rx_DV) begin
      if (cnt_q == T_LAST) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (bus.i_Rx_DV) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_Rx_Byte == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          scmd_d  = bus.i_Rx_Byte;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d   = bus.i_Rx_Byte;
`endif
          state_d = S_LEN;
        end
        S_LEN: begin
          if (bus.i_Rx_Byte == PL_B) begin
            idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_d   = chk_q ^ bus.i_Rx_Byte;
`endif
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          for (int k = 0; k < PL; k++) begin
            if (idx_q == 8'(k)) shadow_d[8*k +: 8] = bus.i_Rx_Byte;
          end
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ bus.i_Rx_Byte;
`endif
          if (idx_q == PL_LST) begin
            idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            cmd_d   = scmd_q;
            pat_d   = shadow_d[N_NEURONS-1:0];
            vld_d   = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK: begin
          if (bus.i_Rx_Byte == chk_q) begin
            cmd_d = scmd_q;
            pat_d = shadow_q[N_NEURONS-1:0];
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      scmd_q   <= '0;
      shadow_q <= '0;
      cmd_q    <= '0;
      pat_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      scmd_q   <= scmd_d;
      shadow_q <= shadow_d;
      cmd_q    <= cmd_d;
      pat_q    <= pat_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign bus.o_Cmd         = cmd_q;
  assign bus.o_Pattern     = pat_q;
  assign bus.o_Frame_Valid = vld_q;
  assign bus.o_Frame_Error = err_q;
  assign bus.o_Busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser (N=16, timeout 50).
// Adapts frame layout to UART_FRAME_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_frame_parser;
  localparam int N = 16;
  localparam int T = 50;

  typedef struct packed {
    logic         vld;
    logic         err;
    logic [7:0]   cmd;
    logic [N-1:0] pat;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_parser_if #(.N_NEURONS(N)) bus ();

  uart_frame_parser #(
    .N_NEURONS(N),
    .TIMEOUT_CLKS(T),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] tx_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_cmd = 8'h00;
  logic [N-1:0] m_pat = '0;
  ev_t        e, o;
  bit         to;

  always @(negedge clk) begin
    if (bus.o_Frame_Valid || bus.o_Frame_Error)
      obs_q.push_back({bus.o_Frame_Valid, bus.o_Frame_Error,
                       bus.o_Cmd, bus.o_Pattern});
  end

  function automatic string fmt(ev_t v);
    return $sformatf("v=%0b e=%0b cmd=%h pat=%h",
                     v.vld, v.err, v.cmd, v.pat);
  endfunction

  function automatic logic [7:0] xsum(logic [7:0] c, logic [N-1:0] p);
    return c ^ 8'd2 ^ p[7:0] ^ p[15:8];
  endfunction

  task automatic send_tx();
    while (tx_q.size() > 0) begin
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = tx_q.pop_front();
      @(negedge clk);
    end
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
  endtask

  task automatic push_good(input logic [7:0] c, input logic [N-1:0] p);
    tx_q.push_back(8'hA5);
    tx_q.push_back(c);
    tx_q.push_back(8'd2);
    tx_q.push_back(p[7:0]);
    tx_q.push_back(p[15:8]);
`ifdef UART_FRAME_CHECKSUM_EN
    tx_q.push_back(xsum(c, p));
`endif
    exp_q.push_back({1'b1, 1'b0, c, p});
    m_cmd = c;
    m_pat = p;
  endtask

  task automatic push_err();
    exp_q.push_back({1'b0, 1'b1, m_cmd, m_pat});
  endtask

  task automatic wait_obs(input int n, input int budget, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= n) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.o_Cmd !== 8'h00) begin
      n_bad++; $display("FAIL reset_cmd got %h want 00", bus.o_Cmd);
    end
    n_cmp++;
    if (bus.o_Pattern !== '0) begin
      n_bad++; $display("FAIL reset_pat got %h want 0000", bus.o_Pattern);
    end
    n_cmp++;
    if (bus.o_Frame_Valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_vld got %b want 0", bus.o_Frame_Valid);
    end
    n_cmp++;
    if (bus.o_Frame_Error !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got %b want 0", bus.o_Frame_Error);
    end
    n_cmp++;
    if (bus.o_Busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", bus.o_Busy);
    end
  endtask

  task automatic test_good_frame();
    push_good(8'h01, 16'h1234);
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL good_frame got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL good_extra got %0d pulses want 0", obs_q.size());
    end
    n_cmp++;
    if (bus.o_Busy !== 1'b0) begin
      n_bad++; $display("FAIL good_busy got %b want 0", bus.o_Busy);
    end
    obs_q.delete();
  endtask

  task automatic test_bad_chk();
`ifdef UART_FRAME_CHECKSUM_EN
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h34, 8'h12, 8'h26};
    push_err();
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL bad_chk got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL chk_extra got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
`endif
  endtask

  task automatic test_bad_len();
    tx_q = '{8'hA5, 8'h07, 8'h03};
    push_err();
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    send_tx();
    push_good(8'h02, 16'hABCD);
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL bad_len got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL len_extra got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    tx_q = '{8'hA5, 8'h01};
    send_tx();
    n_cmp++;
    if (bus.o_Busy !== 1'b1) begin
      n_bad++; $display("FAIL to_busy_hi got %b want 1", bus.o_Busy);
    end
    push_err();
    wait_obs(exp_q.size(), T + 10, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL timeout got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (T + 5) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL to_once got %0d pulses want 0", obs_q.size());
    end
    n_cmp++;
    if (bus.o_Busy !== 1'b0) begin
      n_bad++; $display("FAIL to_busy_lo got %b want 0", bus.o_Busy);
    end
    obs_q.delete();
    // byte lands on the last cycle before expiry: frame survives
    tx_q = '{8'hA5, 8'h01};
    send_tx();
    repeat (T - 1) @(negedge clk);
    push_good(8'h01, 16'hBEEF);
    void'(tx_q.pop_front());
    void'(tx_q.pop_front());
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL to_edge got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL edge_extra got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_garbage();
    tx_q = '{8'h00, 8'hFF, 8'h5A};
    push_good(8'hA5, 16'hA5A5);
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL garbage got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL garb_extra got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    push_good(8'h10, 16'h0F0F);
    push_good(8'h20, 16'hF00D);
    send_tx();
    wait_obs(exp_q.size(), 20, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL b2b got %s want %s", fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_extra got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    tx_q = '{8'hA5, 8'h01, 8'h02};
    send_tx();
    n_cmp++;
    if (bus.o_Busy !== 1'b1) begin
      n_bad++; $display("FAIL rm_busy_hi got %b want 1", bus.o_Busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cmd = 8'h00;
    m_pat = '0;
    n_cmp++;
    if (bus.o_Cmd !== m_cmd) begin
      n_bad++; $display("FAIL rm_cmd got %h want %h", bus.o_Cmd, m_cmd);
    end
    n_cmp++;
    if (bus.o_Pattern !== m_pat) begin
      n_bad++; $display("FAIL rm_pat got %h want %h", bus.o_Pattern, m_pat);
    end
    n_cmp++;
    if (bus.o_Busy !== 1'b0) begin
      n_bad++; $display("FAIL rm_busy_lo got %b want 0", bus.o_Busy);
    end
    repeat (T + 10) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL rm_pulse got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_garbage();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
